aes_key_expander: RTL and testbench
===================================

Name: aes_key_expander

Overview:
Iterative AES-128 key-expansion sequencer. Accepts a cipher key over a valid/ready handshake and drives one shared aes_key_schedule instance for NUM_ROUNDS cycles, one round per cycle. Stores all round keys, including round 0 (the cipher key itself), in an internal register file. Serves round keys through an indexed read port to the encrypt/decrypt round datapath; decrypt reads indices in reverse order.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; legal range 1..10, bounded by the rcon table of aes_key_schedule.
REG_READ, 1, 1 = registered read port (1-cycle latency); 0 = combinational read.

Ports:
clk_in  input  1  system clock; all state updates on the rising edge.
rst_n_in  input  1  asynchronous, active-low reset.
key_valid_in  input  1  a new cipher key is presented on key_in.
key_ready_out  output  1  the block can accept a key this cycle.
key_in  input  128  cipher key, row-major state layout (bits [127:96] = row 0).
busy_out  output  1  expansion in progress.
keys_valid_out  output  1  all NUM_ROUNDS+1 round keys are stored and readable.
rk_addr_in  input  4  round-key index to read, 0..NUM_ROUNDS.
rk_out  output  128  round key at rk_addr_in, same layout as key_in.

Behaviour:
- Reset (asynchronous assert, synchronous release): state = IDLE. All outputs reset to 0 except key_ready_out = 1. Register file cleared to 0, round counter cleared to 0.
- FSM states: IDLE, EXPAND, DONE.
- IDLE: key_ready_out = 1. A handshake (key_valid_in & key_ready_out) stores key_in into entry 0, sets the round counter to 1 and moves to EXPAND.
- EXPAND:
  - key_ready_out = 0, busy_out = 1, keys_valid_out = 0.
  - Each cycle, the schedule instance is driven with round_in = counter and key_in = entry[counter-1]; its key_out is written to entry[counter].
  - When counter == NUM_ROUNDS, the write completes and the FSM moves to DONE. Otherwise the counter increments.
  - Exactly NUM_ROUNDS cycles are spent in EXPAND.
  - key_valid_in is ignored in this state.
- DONE:
  - keys_valid_out = 1, key_ready_out = 1, busy_out = 0.
  - A new handshake in DONE behaves exactly as in IDLE: entry 0 is overwritten, keys_valid_out drops to 0 the next cycle, and the FSM enters EXPAND.
- Latency: handshake at cycle T → keys_valid_out = 1 at cycle T+1+NUM_ROUNDS.
- Register file is written only by the handshake (entry 0) and by EXPAND (entries 1..NUM_ROUNDS).
- Read port:
  - REG_READ = 1: rk_out is updated on each edge to the entry indexed by rk_addr_in sampled on that edge.
  - REG_READ = 0: rk_out is combinational from rk_addr_in.
  - Reads are legal in any state. During EXPAND the returned data is stale or partial; consumers gate reads on keys_valid_out.
  - rk_addr_in > NUM_ROUNDS returns 128'h0.
- Round counter is 4 bits and never exceeds NUM_ROUNDS. Only rcon values for indices 1..NUM_ROUNDS are used.
- Reset asserted mid-EXPAND: immediate return to IDLE; keys_valid_out = 0 and the register file is cleared.
- key_valid_in held high continuously in DONE: the block re-expands repeatedly, one accept per NUM_ROUNDS+1 cycles. This is legal.

Test Plan:
- FIPS-197 vector:
  - Stimulus: key_in = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c.
  - Required: keys_valid_out rises 11 cycles after the handshake; busy_out is high for exactly 10 cycles.
  - Required reads: rk[0] = key_in; rk[1] = 128'ha088232a_fa54a36c_fe2c3976_17b13905; rk[10] = 128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6.
- Handshake gating: pulse key_valid_in mid-EXPAND with a different key → ignored; rk[10] still equals the FIPS value; key_ready_out = 0 throughout EXPAND.
- Rekey from DONE: after the FIPS expansion completes, present key 128'h0 → keys_valid_out drops the next cycle and rises 11 cycles after the handshake; rk[0] = 0 and rk[1] = 128'h62626262_63636363_63636363_63636363 (the FIPS-197 all-zero-key round-1 value, row-major).
- Reset mid-operation: deassert rst_n_in in EXPAND cycle 5, asynchronously between edges → outputs return to reset values without a clock edge; after release all reads return 0 and key_ready_out = 1.
- Read port:
  - With REG_READ = 1: sweep rk_addr_in 0..15 in DONE → data appears one cycle after the address; addresses 11..15 return 0.
  - With REG_READ = 0: the same data appears in the same cycle.
- NUM_ROUNDS = 4 build: FIPS key → keys_valid_out after 5 cycles; rk[4] = FIPS round-4 key; rk[5..15] = 0.

Source files
------------

// File: rtl/aes_key_expander.sv
// -----------------------------------------------------------------------------
// aes_key_schedule
//   One AES-128 key-expansion round, purely combinational.
//   Ports:
//     round_in  [3:0]    round index 1..10 (selects rcon; other values use 0)
//     key_in    [127:0]  previous round key, row-major (bits [127:96] = row 0)
//     key_out   [127:0]  next round key, same layout
//
// aes_key_expander
//   Iterative AES-128 key-expansion sequencer. Accepts a cipher key over a
//   valid/ready handshake, runs one shared aes_key_schedule for NUM_ROUNDS
//   cycles, stores every round key (round 0 = cipher key) in a register file
//   and serves them through an indexed read port.
//   Ports:
//     clk_in          system clock, rising edge
//     rst_n_in        asynchronous active-low reset
//     key_valid_in    new cipher key presented on key_in
//     key_ready_out   a key can be accepted this cycle (IDLE or DONE)
//     key_in [127:0]  cipher key, row-major
//     busy_out        expansion in progress
//     keys_valid_out  all NUM_ROUNDS+1 round keys are stored
//     rk_addr_in[3:0] round-key index to read
//     rk_out [127:0]  round key at rk_addr_in (0 for indices > NUM_ROUNDS)
// -----------------------------------------------------------------------------
module aes_key_schedule (
    input  logic [3:0]   round_in,
    input  logic [127:0] key_in,
    output logic [127:0] key_out
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (x^254, 0 maps to 0)
    // followed by the affine transform, so no 256-entry table is needed.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0] w_in  [4];
    logic [31:0] w_out [4];
    logic [31:0] sub_w;

    always_comb begin
        // Gather columns: word c holds rows 0..3 of column c, MSB = row 0.
        for (int c = 0; c < 4; c++) begin
            w_in[c] = {key_in[127 - 8*c -: 8], key_in[95 - 8*c -: 8],
                       key_in[63 - 8*c -: 8],  key_in[31 - 8*c -: 8]};
        end

        // RotWord folded into the byte order of SubWord.
        sub_w = {sbox(w_in[3][23:16]), sbox(w_in[3][15:8]),
                 sbox(w_in[3][7:0]),   sbox(w_in[3][31:24])}
              ^ {rcon(round_in), 24'h000000};

        w_out[0] = w_in[0] ^ sub_w;
        w_out[1] = w_in[1] ^ w_out[0];
        w_out[2] = w_in[2] ^ w_out[1];
        w_out[3] = w_in[3] ^ w_out[2];

        key_out = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                key_out[127 - 8*(4*r + c) -: 8] = w_out[c][31 - 8*r -: 8];
            end
        end
    end

endmodule

module aes_key_expander #(
    parameter int NUM_ROUNDS = 10,
    parameter int REG_READ   = 1
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         key_valid_in,
    output logic         key_ready_out,
    input  logic [127:0] key_in,
    output logic         busy_out,
    output logic         keys_valid_out,
    input  logic [3:0]   rk_addr_in,
    output logic [127:0] rk_out
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] rf_q [0:NUM_ROUNDS];
    logic [127:0] sched_key_in;
    logic [127:0] sched_key_out;
    logic [127:0] rd_data;
    logic         accept;

    assign key_ready_out  = (state_q != EXPAND);
    assign busy_out       = (state_q == EXPAND);
    assign keys_valid_out = (state_q == DONE);
    assign accept         = key_valid_in & key_ready_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = EXPAND;
                    cnt_d   = 4'd1;
                end
            end
            EXPAND: begin
                // Counter parks at NUM_ROUNDS so it never selects an unused rcon.
                if (cnt_q == LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Previous round key feeding the shared schedule: entry[cnt-1].
    always_comb begin
        sched_key_in = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (cnt_q == 4'(i + 1)) sched_key_in = rf_q[i];
        end
    end

    aes_key_schedule u_sched (
        .round_in (cnt_q),
        .key_in   (sched_key_in),
        .key_out  (sched_key_out)
    );

    // Entry 0 only changes on a handshake, entries 1..N only during EXPAND,
    // so the two write paths never collide.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) rf_q[i] <= '0;
        end else begin
            if (accept) rf_q[0] <= key_in;
            if (state_q == EXPAND) begin
                for (int i = 1; i <= NUM_ROUNDS; i++) begin
                    if (cnt_q == 4'(i)) rf_q[i] <= sched_key_out;
                end
            end
        end
    end

    // Out-of-range addresses fall through to zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (rk_addr_in == 4'(i)) rd_data = rf_q[i];
        end
    end

    if (REG_READ != 0) begin : g_reg_read
        logic [127:0] rk_q;
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) rk_q <= '0;
            else           rk_q <= rd_data;
        end
        assign rk_out = rk_q;
    end else begin : g_comb_read
        assign rk_out = rd_data;
    end

endmodule

// File: tb/tb_aes_key_expander.sv
module tb_aes_key_expander;

    localparam logic [127:0] FIPS_KEY  = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
    localparam logic [127:0] FIPS_R1   = 128'ha088232a_fa54a36c_fe2c3976_17b13905;
    localparam logic [127:0] FIPS_R4   = 128'hefa8b6db_4452710b_a55b25ad_417f3b00;
    localparam logic [127:0] FIPS_R10  = 128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6;
    localparam logic [127:0] ZERO_R1   = 128'h62626262_63636363_63636363_63636363;
    localparam logic [127:0] OTHER_KEY = 128'h00112233_44556677_8899aabb_ccddeeff;

    localparam logic [2047:0] SBOX_V = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [79:0] RCON_V = 80'h01020408102040801b36;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [127:0] key = '0;
    logic [3:0]   rk_addr = 4'd0;

    logic [2:0]   ready_w, busy_w, kv_w;
    logic [127:0] rk_w [3];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: combinational read; 2: four rounds.
    aes_key_expander u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .key_valid_in(key_valid), .key_ready_out(ready_w[0]),
        .key_in(key), .busy_out(busy_w[0]), .keys_valid_out(kv_w[0]),
        .rk_addr_in(rk_addr), .rk_out(rk_w[0]));

    aes_key_expander #(.NUM_ROUNDS(10), .REG_READ(0)) u_comb (
        .clk_in(clk), .rst_n_in(rst_n), .key_valid_in(key_valid), .key_ready_out(ready_w[1]),
        .key_in(key), .busy_out(busy_w[1]), .keys_valid_out(kv_w[1]),
        .rk_addr_in(rk_addr), .rk_out(rk_w[1]));

    aes_key_expander #(.NUM_ROUNDS(4), .REG_READ(1)) u_r4 (
        .clk_in(clk), .rst_n_in(rst_n), .key_valid_in(key_valid), .key_ready_out(ready_w[2]),
        .key_in(key), .busy_out(busy_w[2]), .keys_valid_out(kv_w[2]),
        .rk_addr_in(rk_addr), .rk_out(rk_w[2]));

    // ---------------- reference model ----------------
    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX_V[2047 - 8*int'(x) -: 8];
    endfunction

    // FIPS-197 word recurrence, returning round n in row-major layout.
    function automatic logic [127:0] model_round_key(input logic [127:0] k, input int n);
        logic [31:0]  w [4];
        logic [31:0]  t;
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            w[c] = {k[127-8*c -: 8], k[95-8*c -: 8], k[63-8*c -: 8], k[31-8*c -: 8]};
        for (int j = 1; j <= n; j++) begin
            t = {w[3][23:0], w[3][31:24]};
            t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
            t = t ^ {RCON_V[79 - 8*(j-1) -: 8], 24'h0};
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
        end
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                res[127 - 8*(4*r+c) -: 8] = w[c][31 - 8*r -: 8];
        return res;
    endfunction

    int           m_n  [3] = '{10, 10, 4};
    bit           m_rr [3] = '{1'b1, 1'b0, 1'b1};
    int           m_left [3];
    bit           m_done [3];
    logic [127:0] m_file [3][16];
    logic [127:0] m_full [3][16];
    logic [127:0] m_rkreg [3];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    m_left[i] = 0;
                    m_done[i] = 1'b0;
                    m_rkreg[i] = '0;
                    for (int j = 0; j < 16; j++) m_file[i][j] = '0;
                end else begin
                    int a;
                    a = int'(rk_addr);
                    if (m_rr[i]) m_rkreg[i] = (a <= m_n[i]) ? m_file[i][a] : '0;
                    if (m_left[i] > 0) begin
                        int idx;
                        idx = m_n[i] - m_left[i] + 1;
                        m_file[i][idx] = m_full[i][idx];
                        m_left[i]--;
                        if (m_left[i] == 0) m_done[i] = 1'b1;
                    end else if (key_valid) begin
                        m_file[i][0] = key;
                        for (int j = 1; j <= m_n[i]; j++) m_full[i][j] = model_round_key(key, j);
                        m_left[i] = m_n[i];
                        m_done[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    int a;
                    logic [127:0] exp_rk;
                    a = int'(rk_addr);
                    exp_rk = m_rr[i] ? m_rkreg[i] : ((a <= m_n[i]) ? m_file[i][a] : '0);
                    check($sformatf("dut%0d ready", i), 128'(ready_w[i]), 128'(m_left[i] == 0));
                    check($sformatf("dut%0d busy", i), 128'(busy_w[i]), 128'(m_left[i] > 0));
                    check($sformatf("dut%0d keys_valid", i), 128'(kv_w[i]), 128'(m_done[i]));
                    check($sformatf("dut%0d rk[%0d]", i, a), rk_w[i], exp_rk);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_key(input logic [127:0] k);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key = k;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic measure(output int lat0, output int busy0, output int lat4,
                           output int busy4, output logic kv_first);
        lat0 = 0; busy0 = 0; lat4 = 0; busy4 = 0; kv_first = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) kv_first = kv_w[0];
            if (busy_w[0]) busy0++;
            if (busy_w[2]) busy4++;
            if (kv_w[0] && lat0 == 0) lat0 = k;
            if (kv_w[2] && lat4 == 0) lat4 = k;
        end
    endtask

    // Comb port shows data in the address cycle, registered ports one edge later.
    task automatic read_chk(input int a, input logic [127:0] exp10, input logic [127:0] exp4);
        @(posedge clk); #1;
        rk_addr = 4'(a);
        #1;
        check($sformatf("comb rk[%0d]", a), rk_w[1], exp10);
        @(posedge clk); #1;
        check($sformatf("reg rk[%0d]", a), rk_w[0], exp10);
        check($sformatf("r4 rk[%0d]", a), rk_w[2], exp4);
    endtask

    task automatic sweep();
        for (int a = 0; a < 16; a++) begin
            @(posedge clk); #1;
            rk_addr = 4'(a);
            if (a > 10) begin
                #1;
                check($sformatf("comb rk[%0d] out of range", a), rk_w[1], '0);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat0, busy0, lat4, busy4, bad;
        logic kvf;

        // Model pinned against published values.
        check("model r1", model_round_key(FIPS_KEY, 1), FIPS_R1);
        check("model r4", model_round_key(FIPS_KEY, 4), FIPS_R4);
        check("model r10", model_round_key(FIPS_KEY, 10), FIPS_R10);
        check("model zero r1", model_round_key('0, 1), ZERO_R1);

        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 128'(ready_w[0]), 128'd1);
        check("reset busy", 128'(busy_w[0]), 128'd0);
        check("reset keys_valid", 128'(kv_w[0]), 128'd0);
        check("reset rk", rk_w[0], '0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // FIPS-197 expansion
        do_key(FIPS_KEY);
        measure(lat0, busy0, lat4, busy4, kvf);
        check("fips latency", 128'(lat0), 128'd11);
        check("fips busy cycles", 128'(busy0), 128'd10);
        check("r4 latency", 128'(lat4), 128'd5);
        check("r4 busy cycles", 128'(busy4), 128'd4);
        read_chk(0, FIPS_KEY, FIPS_KEY);
        read_chk(1, FIPS_R1, FIPS_R1);
        read_chk(4, FIPS_R4, FIPS_R4);
        read_chk(10, FIPS_R10, '0);
        read_chk(5, model_round_key(FIPS_KEY, 5), '0);
        sweep();

        // Rekey from DONE with the all-zero key
        do_key('0);
        measure(lat0, busy0, lat4, busy4, kvf);
        check("rekey keys_valid drop", 128'(kvf), 128'd0);
        check("rekey latency", 128'(lat0), 128'd11);
        read_chk(0, '0, '0);
        read_chk(1, ZERO_R1, ZERO_R1);

        // Handshake gating: a second key mid-EXPAND must be ignored
        do_key(FIPS_KEY);
        @(posedge clk); #1;
        key_valid = 1'b1;
        key = OTHER_KEY;
        @(posedge clk); #1;
        key_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (busy_w[0] && ready_w[0]) bad++;
        end
        check("ready low in EXPAND", 128'(bad), 128'd0);
        check("gated keys_valid", 128'(kv_w[0]), 128'd1);
        read_chk(10, FIPS_R10, '0);
        read_chk(4, FIPS_R4, FIPS_R4);
        read_chk(0, FIPS_KEY, FIPS_KEY);

        // Asynchronous reset in the fifth EXPAND cycle
        do_key(ZERO_R1);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst busy", 128'(busy_w[0]), 128'd0);
        check("async rst ready", 128'(ready_w[0]), 128'd1);
        check("async rst keys_valid", 128'(kv_w[0]), 128'd0);
        check("async rst rk reg", rk_w[0], '0);
        check("async rst rk comb", rk_w[1], '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        read_chk(0, '0, '0);
        read_chk(1, '0, '0);
        read_chk(10, '0, '0);
        check("post rst ready", 128'(ready_w[0]), 128'd1);
        sweep();

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
